// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// FSM state encoding, default memory latency, wait-counter width and the
// arbitration pick function.
package arb_pkg;

    // Arbiter FSM states; exactly one transaction is in flight outside IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default memory read latency (mem_en to valid mem_rdata), legal 1..7.
    localparam int unsigned LATENCY_DEF = 2;

    // WAIT down-counter width; holds LATENCY-1 for any legal latency.
    localparam int unsigned CNT_W = 3;

    // Requester choice: a lone request wins outright, a contended request
    // goes to whoever was not served last (1 = requester 1).
    function automatic logic arb_pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) begin
            return ~last;
        end
        return r1;
    endfunction

endpackage

// File: rtl/MUX_32b_2_1.sv
// Two-input word multiplexer used on the arbiter address and write-data paths.
// Ports:
//   in0, in1 : data inputs (in0 selected when s = 0)
//   s        : select
//   y        : selected word
module MUX_32b_2_1 #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         s,
    output logic [W-1:0] y
);

    assign y = s ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port. One transaction at a time
// runs IDLE -> ISSUE -> WAIT (LATENCY cycles) -> DONE. Contended requests
// alternate, starting with requester 0 after reset.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req0/1              : level transaction requests, held until done
//   addr0/1, wdata0/1   : requester address / write data
//   we0/1               : requester write enable (1 = write)
//   gnt0/1              : requester owns the port (ISSUE..DONE)
//   done0/1             : one-cycle completion pulse
//   rdata               : captured read data, valid with done on a read
//   mem_en, mem_we      : memory strobe / write enable (ISSUE only)
//   mem_addr, mem_wdata : selected requester's address / write data
//   mem_rdata           : memory read data
//   sel                 : current mux select (0 = requester 0)
//   busy                : FSM not in IDLE
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we0,
    input  logic              we1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sel,
    output logic              busy
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             pick_c;
    logic             we_sel_c;

    // Arbitration decision, used only while IDLE.
    assign pick_c   = arb_pick(req0, req1, last);

    // Write enable of the owning requester; requesters hold it until done.
    assign we_sel_c = sel ? we1 : we0;

    // Address and write-data paths steered by the registered select.
    MUX_32b_2_1 #(
        .W (DATA_W)
    ) u_addr_mux (
        .in0 (addr0),
        .in1 (addr1),
        .s   (sel),
        .y   (mem_addr)
    );

    MUX_32b_2_1 #(
        .W (DATA_W)
    ) u_wdata_mux (
        .in0 (wdata0),
        .in1 (wdata1),
        .s   (sel),
        .y   (mem_wdata)
    );

    // Arbiter FSM; every output is registered alongside the state transition
    // so it is already valid in the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= 1'b1;
            sel    <= 1'b0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            busy   <= 1'b0;
            rdata  <= '0;
        end else begin
            // Single-cycle strobes default low.
            done0  <= 1'b0;
            done1  <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state  <= ISSUE;
                        sel    <= pick_c;
                        gnt0   <= ~pick_c;
                        gnt1   <= pick_c;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        mem_we <= pick_c ? we1 : we0;
                    end
                end

                ISSUE: begin
                    state <= WAIT;
                    cnt   <= CNT_W'(LATENCY - 1);
                end

                WAIT: begin
                    if (cnt == '0) begin
                        // Final wait cycle: memory data is valid now.
                        state <= DONE;
                        done0 <= ~sel;
                        done1 <= sel;
                        if (!we_sel_c) begin
                            rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                    last  <= sel;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
